ysyx_24100029_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order WB stage and the multi-cycle MDU (mul/div) result path.
//  The MDU result path is buffered in a small FIFO. The WB stage has priority.
//  A starvation counter forces an MDU drain by back-pressuring WB.

---
 rtl/ysyx_24100029_wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ysyx_24100029_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_wb_arbiter.sv
// Register-file write-port arbiter: the WB stage has priority, and MDU results
// wait in a small FIFO. A starvation counter forces one MDU drain, and younger
// WB writes kill stale MDU results.
module ysyx_24100029_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_value,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_value,
  input  logic [4:0]      hz_rs1,
  input  logic [4:0]      hz_rs2,
  output logic            hz_stall,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_CNT = SW'(STARVE_LIMIT);

  typedef enum logic {PIPE_PRI, MDU_FORCE} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [AW-1:0]     rptr_q, wptr_q;
  logic [AW:0]       count_q;
  logic              vld_q  [FIFO_DEPTH];
  logic [4:0]        rdMem_q  [FIFO_DEPTH];
  logic [XLEN-1:0]   dataMem_q[FIFO_DEPTH];
  logic              rfWen_q;
  logic [4:0]        rfWaddr_q;
  logic [XLEN-1:0]   rfWdata_q;

  logic fifoEmpty, fifoFull, headValid, push, headPop;
  logic wbGrant, fifoGrant, grantWrite, killEn;
  logic [4:0] headRd;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == FULL_CNT);
  assign headValid = vld_q[rptr_q];
  assign headRd    = rdMem_q[rptr_q];
  assign push      = mdu_valid && !fifoFull;
  assign killEn    = wbGrant && wb_wen && (wb_rd != 5'd0);
  assign grantWrite = (wbGrant && wb_wen && (wb_rd != 5'd0)) ||
                      (fifoGrant && (headRd != 5'd0));

  assign mdu_ready = !fifoFull;
  assign rf_wen    = rfWen_q;
  assign rf_waddr  = rfWaddr_q;
  assign rf_wdata  = rfWdata_q;

  // Arbitration FSM: grants, head pops of killed entries, and the starvation counter.
  always_comb begin
    wb_ready  = 1'b1;
    wbGrant   = 1'b0;
    fifoGrant = 1'b0;
    headPop   = 1'b0;
    state_d   = state_q;
    starve_d  = starve_q;
    unique case (state_q)
      PIPE_PRI: begin
        wbGrant = wb_valid;
        if (!wb_valid && !fifoEmpty) begin
          headPop   = 1'b1;
          fifoGrant = headValid;
        end
        if (fifoEmpty || fifoGrant) begin
          starve_d = '0;
        end else if (wbGrant && (starve_q != LIMIT_CNT)) begin
          starve_d = starve_q + 1'b1;
        end
        if (starve_d == LIMIT_CNT) begin
          state_d = MDU_FORCE;
        end
      end
      MDU_FORCE: begin
        wb_ready = 1'b0;
        if (!fifoEmpty) begin
          headPop   = 1'b1;
          fifoGrant = headValid;
        end
        starve_d = '0;
        state_d  = PIPE_PRI;
      end
      default: begin
        state_d = PIPE_PRI;
      end
    endcase
  end

  // Decode hazard: a nonzero source matching a live buffered MDU destination.
  always_comb begin
    hz_stall = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_q[i] && (rdMem_q[i] != 5'd0) &&
          ((rdMem_q[i] == hz_rs1) || (rdMem_q[i] == hz_rs2))) begin
        hz_stall = 1'b1;
      end
    end
  end

  // FIFO storage, supersede kills, FSM state and the registered write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= PIPE_PRI;
      starve_q  <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      rfWen_q   <= 1'b0;
      rfWaddr_q <= '0;
      rfWdata_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        vld_q[i]     <= 1'b0;
        rdMem_q[i]   <= '0;
        dataMem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (killEn && vld_q[i] && (rdMem_q[i] == wb_rd)) begin
          vld_q[i] <= 1'b0;
        end
      end
      if (headPop) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + 1'b1;
      end
      if (push) begin
        rdMem_q[wptr_q]   <= mdu_rd;
        dataMem_q[wptr_q] <= mdu_value;
        vld_q[wptr_q]     <= 1'b1;
        wptr_q            <= wptr_q + 1'b1;
      end
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(headPop);
      rfWen_q <= grantWrite;
      if (wbGrant) begin
        rfWaddr_q <= wb_rd;
        rfWdata_q <= wb_value;
      end else if (fifoGrant) begin
        rfWaddr_q <= headRd;
        rfWdata_q <= dataMem_q[rptr_q];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_wb_arbiter.sv
// Bench for the register-file write arbiter: directed cycles push expected
// register writes into a queue, and a monitor pops them as rf_wen appears.
module tb_ysyx_24100029_wb_arbiter;

  logic        clock, reset;
  logic        wbValid, wbReady, wbWen;
  logic [4:0]  wbRd;
  logic [31:0] wbValue;
  logic        mduValid, mduReady;
  logic [4:0]  mduRd;
  logic [31:0] mduValue;
  logic [4:0]  hzRs1, hzRs2;
  logic        hzStall, rfWen;
  logic [4:0]  rfWaddr;
  logic [31:0] rfWdata;

  int vectors = 0;
  int miscompares = 0;
  logic [36:0] expQ[$];

  ysyx_24100029_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wbValid), .wb_ready(wbReady), .wb_wen(wbWen), .wb_rd(wbRd), .wb_value(wbValue),
    .mdu_valid(mduValid), .mdu_ready(mduReady), .mdu_rd(mduRd), .mdu_value(mduValue),
    .hz_rs1(hzRs1), .hz_rs2(hzRs2), .hz_stall(hzStall),
    .rf_wen(rfWen), .rf_waddr(rfWaddr), .rf_wdata(rfWdata)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Sets one cycle of inputs just after a rising edge and returns at the falling edge.
  task automatic applyStimulus(input logic wv, input logic [4:0] wrd, input logic [31:0] wval,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] mval);
    @(posedge clock);
    #1;
    wbValid  = wv;
    wbRd     = wrd;
    wbValue  = wval;
    mduValid = mv;
    mduRd    = mrd;
    mduValue = mval;
    @(negedge clock);
  endtask

  task automatic expectWrite(input logic [4:0] rd, input logic [31:0] val);
    expQ.push_back({rd, val});
  endtask

  // Scoreboard monitor: every register-file write must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && rfWen) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write: got x%0d=0x%0h, required no write", rfWaddr, rfWdata);
      end else begin
        logic [36:0] e;
        e = expQ.pop_front();
        checkOutput("rf_write", {27'b0, rfWaddr, rfWdata}, {27'b0, e});
      end
    end
  end

  initial begin
    reset = 1'b1;
    wbValid = 0; wbWen = 1; wbRd = 0; wbValue = 0;
    mduValid = 0; mduRd = 0; mduValue = 0;
    hzRs1 = 0; hzRs2 = 0;

    // Test 1: reset state, then a WB write to x5 and an x0 write that must not reach the file.
    repeat (2) @(negedge clock);
    checkOutput("reset_rf_wen", 64'(rfWen), 64'd0);
    checkOutput("reset_rf_waddr", 64'(rfWaddr), 64'd0);
    checkOutput("reset_rf_wdata", 64'(rfWdata), 64'd0);
    checkOutput("reset_mdu_ready", 64'(mduReady), 64'd1);
    checkOutput("reset_hz_stall", 64'(hzStall), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(1, 5'd5, 32'h1234, 0, 0, 0);
    checkOutput("t1_wb_ready", 64'(wbReady), 64'd1);
    expectWrite(5'd5, 32'h1234);
    applyStimulus(1, 5'd0, 32'hDEAD, 0, 0, 0);
    checkOutput("t1_x0_wb_ready", 64'(wbReady), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Test 2: lone MDU result drains the cycle after it is buffered.
    hzRs1 = 5'd7;
    applyStimulus(0, 0, 0, 1, 5'd7, 32'hAAAA);
    checkOutput("t2_mdu_ready", 64'(mduReady), 64'd1);
    checkOutput("t2_no_bypass_stall", 64'(hzStall), 64'd0);
    expectWrite(5'd7, 32'hAAAA);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2_buffered_stall", 64'(hzStall), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2_drained_stall", 64'(hzStall), 64'd0);
    checkOutput("t2_mdu_ready_after", 64'(mduReady), 64'd1);
    hzRs1 = 5'd0;

    // Test 3: WB streams for six cycles; the starved MDU entry is forced out on the fifth.
    applyStimulus(0, 0, 0, 1, 5'd7, 32'h77);
    applyStimulus(1, 5'd13, 32'h130, 0, 0, 0);
    checkOutput("t3_ready_c1", 64'(wbReady), 64'd1);
    expectWrite(5'd13, 32'h130);
    applyStimulus(1, 5'd14, 32'h140, 0, 0, 0);
    checkOutput("t3_ready_c2", 64'(wbReady), 64'd1);
    expectWrite(5'd14, 32'h140);
    applyStimulus(1, 5'd15, 32'h150, 0, 0, 0);
    checkOutput("t3_ready_c3", 64'(wbReady), 64'd1);
    expectWrite(5'd15, 32'h150);
    applyStimulus(1, 5'd16, 32'h160, 0, 0, 0);
    checkOutput("t3_ready_c4", 64'(wbReady), 64'd1);
    expectWrite(5'd16, 32'h160);
    applyStimulus(1, 5'd17, 32'h170, 0, 0, 0);
    checkOutput("t3_ready_c5_forced", 64'(wbReady), 64'd0);
    expectWrite(5'd7, 32'h77);
    applyStimulus(1, 5'd17, 32'h170, 0, 0, 0);
    checkOutput("t3_ready_c6", 64'(wbReady), 64'd1);
    expectWrite(5'd17, 32'h170);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Test 4: a younger WB write to x9 kills the buffered x9 result.
    applyStimulus(1, 5'd20, 32'h200, 1, 5'd9, 32'h1);
    expectWrite(5'd20, 32'h200);
    applyStimulus(1, 5'd9, 32'h2, 0, 0, 0);
    checkOutput("t4_wb_ready", 64'(wbReady), 64'd1);
    expectWrite(5'd9, 32'h2);
    hzRs1 = 5'd9;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4_killed_no_stall", 64'(hzStall), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4_mdu_ready", 64'(mduReady), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    hzRs1 = 5'd0;

    // Test 5: two buffered results fill the FIFO, a third is refused, order is preserved.
    applyStimulus(1, 5'd21, 32'h210, 1, 5'd11, 32'hB1);
    checkOutput("t5_ready_a", 64'(mduReady), 64'd1);
    expectWrite(5'd21, 32'h210);
    applyStimulus(1, 5'd22, 32'h220, 1, 5'd12, 32'hB2);
    checkOutput("t5_ready_b", 64'(mduReady), 64'd1);
    expectWrite(5'd22, 32'h220);
    applyStimulus(1, 5'd23, 32'h230, 1, 5'd13, 32'hB3);
    checkOutput("t5_full_c", 64'(mduReady), 64'd0);
    expectWrite(5'd23, 32'h230);
    applyStimulus(0, 0, 0, 1, 5'd13, 32'hB3);
    checkOutput("t5_full_d", 64'(mduReady), 64'd0);
    expectWrite(5'd11, 32'hB1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5_ready_e", 64'(mduReady), 64'd1);
    expectWrite(5'd12, 32'hB2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Test 6: hazard detection, x0 exclusion, and reset while full.
    hzRs2 = 5'd3;
    applyStimulus(1, 5'd24, 32'h240, 1, 5'd3, 32'h33);
    checkOutput("t6_stall_not_yet", 64'(hzStall), 64'd0);
    expectWrite(5'd24, 32'h240);
    applyStimulus(1, 5'd25, 32'h250, 1, 5'd0, 32'h0);
    checkOutput("t6_stall_rs2", 64'(hzStall), 64'd1);
    expectWrite(5'd25, 32'h250);
    hzRs2 = 5'd0;
    applyStimulus(1, 5'd26, 32'h260, 0, 0, 0);
    checkOutput("t6_x0_no_stall", 64'(hzStall), 64'd0);
    checkOutput("t6_full", 64'(mduReady), 64'd0);
    #2 reset = 1'b1;
    #1 checkOutput("t6_async_rf_wen", 64'(rfWen), 64'd0);
    wbValid = 0; mduValid = 0;
    hzRs2 = 5'd3;
    repeat (2) @(negedge clock);
    checkOutput("t6_reset_mdu_ready", 64'(mduReady), 64'd1);
    checkOutput("t6_reset_hz_stall", 64'(hzStall), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t6_post_reset_stall", 64'(hzStall), 64'd0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

    checkOutput("pending_writes", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
